// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one external combinational ALU between two requesters:
//   port 0 - execute stage (data-processing ops, optional NZCV update via p0_s)
//   port 1 - PC/address unit (pass A, A+4, A+B+4; never updates flags)
// Each operation takes three cycles: accept (IDLE), evaluate (EXEC), report
// (DONE). Arbitration is round-robin on the last owner. The block owns the
// architectural NZCV register and feeds its C bit to the ALU carry-in.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   p0_req/op/a/b/s             port 0 request, opcode, operands, flag-update
//   p0_ack/done/err             port 0 accept (comb), result pulse, illegal-op
//   p1_req/op/a/b               port 1 request, opcode, operands
//   p1_ack/done/err             port 1 accept (comb), result pulse, illegal-op
//   result                      registered ALU result (valid with done)
//   flags                       NZCV register {N,Z,C,V}
//   busy                        high whenever the FSM is not idle
//   alu_a/alu_b/alu_op/alu_cin  drive to the external ALU
//   alu_out/alu_c/z/n/v         result and flags returned by the ALU
module alu_arbiter #(
  parameter int         W       = 32,
  parameter logic [4:0] MAX_OP  = 5'b10010,
  parameter logic [4:0] IDLE_OP = 5'b11111
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         p0_req,
  input  logic [4:0]   p0_op,
  input  logic [W-1:0] p0_a,
  input  logic [W-1:0] p0_b,
  input  logic         p0_s,
  output logic         p0_ack,
  output logic         p0_done,
  output logic         p0_err,
  input  logic         p1_req,
  input  logic [4:0]   p1_op,
  input  logic [W-1:0] p1_a,
  input  logic [W-1:0] p1_b,
  output logic         p1_ack,
  output logic         p1_done,
  output logic         p1_err,
  output logic [W-1:0] result,
  output logic [3:0]   flags,
  output logic         busy,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [4:0]   alu_op,
  output logic         alu_cin,
  input  logic [W-1:0] alu_out,
  input  logic         alu_c,
  input  logic         alu_z,
  input  logic         alu_n,
  input  logic         alu_v
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Opcodes above MAX_OP are accepted but never shown to the ALU.
  function automatic logic op_legal(input logic [4:0] op);
    op_legal = (op <= MAX_OP);
  endfunction

  state_t       state_q, state_d;
  logic         ptr_q, ptr_d;        // last owner: 0 = port 0, 1 = port 1
  logic         owner_q, owner_d;
  logic [4:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         s_q, s_d;
  logic [W-1:0] result_q, result_d;
  logic [3:0]   flags_q, flags_d;
  logic         p0_done_q, p0_done_d;
  logic         p1_done_q, p1_done_d;
  logic         p0_err_q, p0_err_d;
  logic         p1_err_q, p1_err_d;

  logic         grant0_s, grant1_s;
  logic         legal_s;

  // Round-robin grant, only offered in IDLE and never while reset is held.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if ((state_q == ST_IDLE) && !reset) begin
      if (p0_req && p1_req) begin
        // Tie: the port that did not own the ALU last time wins.
        if (ptr_q == 1'b1) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = 1'b1;
        end
      end else begin
        grant0_s = p0_req;
        grant1_s = p1_req;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign legal_s = op_legal(op_q);

  // Next-state logic for the FSM, operand latches, result, flags and pulses.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    result_d  = result_q;
    flags_d   = flags_q;
    p0_done_d = 1'b0;
    p1_done_d = 1'b0;
    p0_err_d  = 1'b0;
    p1_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant0_s) begin
          state_d = ST_EXEC;
          ptr_d   = 1'b0;
          owner_d = 1'b0;
          op_d    = p0_op;
          a_d     = p0_a;
          b_d     = p0_b;
          s_d     = p0_s;
        end else if (grant1_s) begin
          state_d = ST_EXEC;
          ptr_d   = 1'b1;
          owner_d = 1'b1;
          op_d    = p1_op;
          a_d     = p1_a;
          b_d     = p1_b;
          s_d     = 1'b0;           // address unit never touches NZCV
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d = ST_DONE;
        if (legal_s) begin
          result_d = alu_out;
          if (s_q) begin
            flags_d = {alu_n, alu_z, alu_c, alu_v};
          end else begin
            flags_d = flags_q;
          end
        end else begin
          result_d = {W{1'b0}};
          flags_d  = flags_q;
        end
        // Pulses are registered here so they appear exactly in DONE.
        if (owner_q == 1'b0) begin
          p0_done_d = 1'b1;
          p0_err_d  = !legal_s;
        end else begin
          p1_done_d = 1'b1;
          p1_err_d  = !legal_s;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 1'b1;
      owner_q   <= 1'b0;
      op_q      <= IDLE_OP;
      a_q       <= {W{1'b0}};
      b_q       <= {W{1'b0}};
      s_q       <= 1'b0;
      result_q  <= {W{1'b0}};
      flags_q   <= 4'b0000;
      p0_done_q <= 1'b0;
      p1_done_q <= 1'b0;
      p0_err_q  <= 1'b0;
      p1_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      s_q       <= s_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      p0_done_q <= p0_done_d;
      p1_done_q <= p1_done_d;
      p0_err_q  <= p0_err_d;
      p1_err_q  <= p1_err_d;
    end
  end

  assign p0_ack  = grant0_s;
  assign p1_ack  = grant1_s;
  assign p0_done = p0_done_q;
  assign p1_done = p1_done_q;
  assign p0_err  = p0_err_q;
  assign p1_err  = p1_err_q;
  assign result  = result_q;
  assign flags   = flags_q;
  assign busy    = (state_q != ST_IDLE);
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  // The ALU sees a real opcode only while evaluating a legal operation.
  assign alu_op  = ((state_q == ST_EXEC) && legal_s) ? op_q : IDLE_OP;
  assign alu_cin = flags_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_s, p1_req;
  logic [4:0]  p0_op, p1_op;
  logic [31:0] p0_a, p0_b, p1_a, p1_b;
  logic        p0_ack, p0_done, p0_err, p1_ack, p1_done, p1_err;
  logic [31:0] result, alu_a, alu_b, alu_out;
  logic [3:0]  flags;
  logic        busy, alu_cin, alu_c, alu_z, alu_n, alu_v;
  logic [4:0]  alu_op;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_op(p0_op), .p0_a(p0_a), .p0_b(p0_b), .p0_s(p0_s),
    .p0_ack(p0_ack), .p0_done(p0_done), .p0_err(p0_err),
    .p1_req(p1_req), .p1_op(p1_op), .p1_a(p1_a), .p1_b(p1_b),
    .p1_ack(p1_ack), .p1_done(p1_done), .p1_err(p1_err),
    .result(result), .flags(flags), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v)
  );

  // Behavioural ALU for the opcodes the bench uses.
  always_comb begin
    logic [32:0] sum;
    sum     = 33'd0;
    alu_out = 32'd0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op)
      5'b01011: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = sum[31:0]; alu_c = sum[32];
        alu_v = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      5'b00010: begin
        alu_out = alu_a - alu_b; alu_c = (alu_a >= alu_b);
        alu_v = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      5'b00101: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
        alu_out = sum[31:0]; alu_c = sum[32];
        alu_v = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      5'b10000: alu_out = alu_a;
      5'b10001: alu_out = alu_a + 32'd4;
      5'b10010: alu_out = alu_a + alu_b + 32'd4;
      default: begin
        alu_out = 32'hDEADBEEF; alu_c = 1'b1; alu_v = 1'b1;
      end
    endcase
    alu_n = alu_out[31];
    alu_z = (alu_out == 32'd0);
  end

  task automatic drive_p0(input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic s);
    p0_req = 1'b1; p0_op = op; p0_a = a; p0_b = b; p0_s = s;
  endtask

  task automatic drive_p1(input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    p1_req = 1'b1; p1_op = op; p1_a = a; p1_b = b;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    p0_req = 1'b0; p1_req = 1'b0; p0_s = 1'b0;
    p0_op = 5'd0; p1_op = 5'd0; p0_a = 32'd0; p0_b = 32'd0; p1_a = 32'd0; p1_b = 32'd0;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", flags); end
    checks++; if (alu_op !== 5'b11111) begin errors++; $display("FAIL reset_alu_op: got %b want 11111", alu_op); end
    checks++; if ({p0_done, p0_err, p1_done, p1_err, p0_ack, p1_ack} !== 6'b0) begin
      errors++; $display("FAIL reset_handshake: got %b want 000000", {p0_done, p0_err, p1_done, p1_err, p0_ack, p1_ack});
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_single_add();
    @(negedge clk); drive_p0(5'b01011, 32'h7FFFFFFF, 32'd1, 1'b1); #1;
    checks++; if (p0_ack !== 1'b1) begin errors++; $display("FAIL add_ack: got %b want 1", p0_ack); end
    @(negedge clk); p0_req = 1'b0; #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy: got %b want 1", busy); end
    checks++; if (alu_op !== 5'b01011) begin errors++; $display("FAIL add_alu_op: got %b want 01011", alu_op); end
    checks++; if (p0_done !== 1'b0) begin errors++; $display("FAIL add_early_done: got %b want 0", p0_done); end
    @(negedge clk); #1;
    checks++; if (p0_done !== 1'b1 || p0_err !== 1'b0) begin errors++; $display("FAIL add_done: got %b%b want 10", p0_done, p0_err); end
    checks++; if (result !== 32'h80000000) begin errors++; $display("FAIL add_result: got %h want 80000000", result); end
    checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL add_flags: got %b want 1001", flags); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || p0_done !== 1'b0) begin errors++; $display("FAIL add_idle: got busy=%b done=%b want 0 0", busy, p0_done); end
    checks++; if (result !== 32'h80000000) begin errors++; $display("FAIL add_result_hold: got %h want 80000000", result); end
  endtask

  task automatic test_tie();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    drive_p0(5'b01011, 32'd2, 32'd3, 1'b0);
    drive_p1(5'b10001, 32'h100, 32'd0);
    #1;
    checks++; if (p0_ack !== 1'b1 || p1_ack !== 1'b0) begin errors++; $display("FAIL tie_first: got %b%b want 10", p0_ack, p1_ack); end
    @(negedge clk); #1;
    checks++; if (p1_ack !== 1'b0) begin errors++; $display("FAIL tie_exec_noack: got %b want 0", p1_ack); end
    @(negedge clk); #1;
    checks++; if (p0_done !== 1'b1 || result !== 32'd5) begin errors++; $display("FAIL tie_p0_done: got done=%b res=%h want 1 5", p0_done, result); end
    checks++; if (p1_ack !== 1'b0 || p1_done !== 1'b0) begin errors++; $display("FAIL tie_done_noack: got ack=%b done=%b want 0 0", p1_ack, p1_done); end
    @(negedge clk); #1;
    checks++; if (p1_ack !== 1'b1 || p0_ack !== 1'b0) begin errors++; $display("FAIL tie_second: got %b%b want 01", p0_ack, p1_ack); end
    @(negedge clk); @(negedge clk); #1;
    checks++; if (p1_done !== 1'b1 || p1_err !== 1'b0 || result !== 32'h104) begin
      errors++; $display("FAIL tie_p1_done: got done=%b err=%b res=%h want 1 0 104", p1_done, p1_err, result);
    end
    checks++; if (p0_done !== 1'b0) begin errors++; $display("FAIL tie_p0_quiet: got %b want 0", p0_done); end
    @(negedge clk); #1;
    checks++; if (p0_ack !== 1'b1 || p1_ack !== 1'b0) begin errors++; $display("FAIL tie_third: got %b%b want 10", p0_ack, p1_ack); end
    @(negedge clk); p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clk); #1;
    checks++; if (p0_done !== 1'b1 || result !== 32'd5) begin errors++; $display("FAIL tie_third_done: got done=%b res=%h want 1 5", p0_done, result); end
    @(negedge clk);
  endtask

  task automatic test_no_s();
    drive_p0(5'b00010, 32'd5, 32'd5, 1'b1); #1;
    checks++; if (p0_ack !== 1'b1) begin errors++; $display("FAIL preset_ack: got %b want 1", p0_ack); end
    @(negedge clk); p0_req = 1'b0;
    @(negedge clk); #1;
    checks++; if (flags !== 4'b0110 || result !== 32'd0) begin errors++; $display("FAIL preset_flags: got %b res=%h want 0110 0", flags, result); end
    @(negedge clk);
    drive_p0(5'b00010, 32'd5, 32'd7, 1'b0);
    @(negedge clk); p0_req = 1'b0;
    @(negedge clk); #1;
    checks++; if (result !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_result: got %h want FFFFFFFE", result); end
    checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL sub_flags_hold: got %b want 0110", flags); end
    @(negedge clk);
  endtask

  task automatic test_adc();
    drive_p0(5'b00101, 32'd1, 32'd1, 1'b1);
    @(negedge clk); p0_req = 1'b0; #1;
    checks++; if (alu_cin !== 1'b1) begin errors++; $display("FAIL adc_cin: got %b want 1", alu_cin); end
    checks++; if (alu_a !== 32'd1 || alu_b !== 32'd1) begin errors++; $display("FAIL adc_operands: got %h %h want 1 1", alu_a, alu_b); end
    @(negedge clk); #1;
    checks++; if (result !== 32'd3) begin errors++; $display("FAIL adc_result: got %h want 3", result); end
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL adc_flags: got %b want 0000", flags); end
    @(negedge clk); #1;
    checks++; if (alu_op !== 5'b11111 || alu_a !== 32'd1) begin errors++; $display("FAIL idle_alu: got op=%b a=%h want 11111 1", alu_op, alu_a); end
  endtask

  task automatic test_illegal();
    drive_p1(5'b10111, 32'd5, 32'd6); #1;
    checks++; if (p1_ack !== 1'b1) begin errors++; $display("FAIL ill_ack: got %b want 1", p1_ack); end
    @(negedge clk); p1_req = 1'b0; #1;
    checks++; if (alu_op !== 5'b11111) begin errors++; $display("FAIL ill_alu_op: got %b want 11111", alu_op); end
    @(negedge clk); #1;
    checks++; if (p1_done !== 1'b1 || p1_err !== 1'b1) begin errors++; $display("FAIL ill_done: got %b%b want 11", p1_done, p1_err); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL ill_result: got %h want 0", result); end
    checks++; if (flags !== 4'b0000 || p0_done !== 1'b0) begin errors++; $display("FAIL ill_flags: got %b p0_done=%b want 0000 0", flags, p0_done); end
    @(negedge clk); #1;
    checks++; if (p1_err !== 1'b0) begin errors++; $display("FAIL ill_err_pulse: got %b want 0", p1_err); end
  endtask

  task automatic test_reset_exec();
    drive_p0(5'b01011, 32'h7FFFFFFF, 32'd1, 1'b1);
    @(negedge clk); p0_req = 1'b0;
    @(negedge clk); #1;
    checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL rx_preset: got %b want 1001", flags); end
    @(negedge clk);
    drive_p0(5'b01011, 32'd1, 32'd1, 1'b1);
    @(negedge clk); p0_req = 1'b0; #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rx_exec: got %b want 1", busy); end
    reset = 1'b1; #1;
    checks++; if (busy !== 1'b0 || flags !== 4'b0000 || result !== 32'd0 || p0_done !== 1'b0) begin
      errors++; $display("FAIL rx_async: got busy=%b flags=%b res=%h done=%b want 0 0000 0 0", busy, flags, result, p0_done);
    end
    checks++; if (alu_op !== 5'b11111 || alu_a !== 32'd0) begin errors++; $display("FAIL rx_alu: got op=%b a=%h want 11111 0", alu_op, alu_a); end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (p0_done !== 1'b0 || flags !== 4'b0000) begin errors++; $display("FAIL rx_no_done: got done=%b flags=%b want 0 0000", p0_done, flags); end
    end
    drive_p1(5'b10000, 32'd55, 32'd0); #1;
    checks++; if (p1_ack !== 1'b1) begin errors++; $display("FAIL rx_fresh_ack: got %b want 1", p1_ack); end
    @(negedge clk); p1_req = 1'b0;
    @(negedge clk); #1;
    checks++; if (p1_done !== 1'b1 || result !== 32'd55) begin errors++; $display("FAIL rx_fresh_done: got done=%b res=%h want 1 37", p1_done, result); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_tie();
    test_no_s();
    test_adc();
    test_illegal();
    test_reset_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters: port 0 is the execute stage (data-processing ops, optional flag update) and port 1 is the PC/address unit (opcodes 5'b10000–5'b10010: pass A, A+4, A+B+4). The block arbitrates round-robin, registers operands, drives the ALU for one evaluation cycle, and captures the result. It owns the architectural NZCV flag register and drives the ALU carry-in from it.

## Interface
- W, 32, datapath width
- MAX_OP, 5'b10010, highest legal opcode
- IDLE_OP, 5'b11111, opcode driven to the ALU when not evaluating

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- p0_req  in  1  port 0 request; held until p0_ack
- p0_op  in  5  port 0 opcode
- p0_a, p0_b  in  W  port 0 operands
- p0_s  in  1  port 0 flag-update request
- p0_ack  out  1  port 0 accepted (this cycle)
- p0_done  out  1  port 0 result valid (one-cycle pulse)
- p0_err  out  1  qualifies p0_done: illegal opcode
- p1_req, p1_op, p1_a, p1_b  in  1/5/W/W  port 1 equivalents (no S bit)
- p1_ack, p1_done, p1_err  out  1  port 1 equivalents
- result  out  W  registered result; valid while any done is high
- flags  out  4  NZCV register {N,Z,C,V}
- busy  out  1  high whenever state != IDLE
- alu_a, alu_b  out  W  ALU operands
- alu_op  out  5  ALU opcode
- alu_cin  out  1  ALU carry-in, equal to flags C
- alu_out  in  W  ALU result
- alu_c, alu_z, alu_n, alu_v  in  1  ALU flag outputs

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: if any req is high, the winner is selected, its ackk is asserted combinationally in the same cycle, and its op, a, b, and s (p1 forces s=0) plus the owner id are latched at the clock edge. Next state is EXEC. With no request, the FSM stays in IDLE.
- Arbitration is round-robin on a last-owner pointer (reset value 1, so port 0 wins the first tie). When only one port requests, that port wins regardless of the pointer. The pointer updates to the winner on acceptance.
- EXEC: alu_a, alu_b, and alu_op are driven from the latched registers, and alu_cin = flags[1]. At the edge, result <= alu_out and the next state is DONE.
  - If the latched s=1 and the op is legal, flags <= {alu_n, alu_z, alu_c, alu_v}; otherwise flags hold.
- Illegal opcode (op > MAX_OP):
  - Accepted normally, but in EXEC alu_op = IDLE_OP.
  - result <= 0 and flags are unchanged.
  - done is asserted with err=1.
- DONE: done and err for the owner only, for exactly one cycle. The next state is IDLE unconditionally. Requests seen in DONE are not acked until IDLE.
- In IDLE and DONE: alu_op = IDLE_OP; alu_a and alu_b hold the last latched values.
- Reset (async, any state):
  - state=IDLE, pointer=1.
  - result, flags, alu_a, and alu_b are 0; alu_op=IDLE_OP.
  - All ack, done, and err outputs are 0 and busy=0.
  - An in-flight operation is discarded: no done pulse and no flag update.
- Requesters must not change op, a, b, or s while req is high and unacked. Dropping req before ack withdraws the request with no side effects.

## Timing
- Request high in IDLE cycle N: ack in N, EXEC in N+1, done and result valid in N+2, flags updated and visible in N+2, IDLE in N+3.
- Throughput is one operation per 3 cycles. Back-to-back requests from both ports alternate: ack at cycles N, N+3, N+6, ...
- ack is combinational from state, req, and pointer. All other outputs are registered or decoded from registered state.
- alu_out and flags are sampled only at the EXEC edge. The ALU must settle within one cycle.
- result holds its value after done until the next EXEC edge.

## Test plan
- Single op: p0 ADD (op 5'b01011, s=1), a=32'h7FFFFFFF, b=1 -> ack@N, done@N+2, result=32'h80000000, flags N=1 Z=0 C=0 V=1.
- Tie: p0 and p1 request in the same cycle after reset, p1 op 5'b10001, a=32'h100 -> p0 acked first; p1 acked 3 cycles later, done with result=32'h104. With both held high, grants alternate p0, p1, p0.
- No-S op: p0 SUB (op 5'b00010, s=0), a=5, b=7, with flags preset to 4'b0110 -> result=32'hFFFFFFFE, flags still 4'b0110.
- ADC carry: flags C=1, then p0 op 5'b00101, a=1, b=1, s=1 -> alu_cin=1 during EXEC, result=3, flags=4'b0000.
- Illegal op: p1 op 5'b10111 -> alu_op=5'b11111 in EXEC, p1_done=1 with p1_err=1, result=0, flags unchanged.
- Reset during EXEC: assert reset in N+1 -> busy, done, and flags go to 0 immediately with no done pulse. A fresh request after release is acked in the first IDLE cycle.
